// File: rtl/multiport_register_file.sv
// Multi-read-port register file with a per-register busy scoreboard and a flattened contents view.
// Define RF_BYPASS_EN to forward same-edge write data to matching read ports.
module multiport_register_file #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_READ = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_READ*ADDR_W-1:0]   address_r_in,
  output logic [NUM_READ*DATA_W-1:0]   reg_r_out,
  output logic [NUM_READ-1:0]          busy_r_out,
  input  logic [ADDR_W-1:0]            address_c_in,
  input  logic [DATA_W-1:0]            data_in,
  input  logic                         rf_write_in,
  input  logic                         issue_in,
  input  logic [ADDR_W-1:0]            address_issue_in,
  output logic [(2**ADDR_W)*DATA_W-1:0] rf_list_out
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]          regs_q [DEPTH];
  logic [DATA_W-1:0]          regs_d [DEPTH];
  logic [DEPTH-1:0]           busy_q, busy_d;
  logic [NUM_READ*DATA_W-1:0] rdata_q, rdata_d;
  logic [NUM_READ-1:0]        rbusy_q, rbusy_d;
  logic [ADDR_W-1:0]          raddr;
  logic                       wr_ok;

  assign wr_ok = rf_write_in && (address_c_in != '0);

  // Issue is applied after the write-clear so a same-address issue leaves the bit set.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wr_ok) begin
      regs_d[address_c_in] = data_in;
    end
    if (rf_write_in) begin
      busy_d[address_c_in] = 1'b0;
    end
    if (issue_in) begin
      busy_d[address_issue_in] = 1'b1;
    end
    regs_d[0] = '0;
    busy_d[0] = 1'b0;
  end

  // Read data comes from pre-edge contents; busy reports the post-edge scoreboard.
  always_comb begin
    rdata_d = '0;
    rbusy_d = '0;
    raddr   = '0;
    for (int k = 0; k < NUM_READ; k++) begin
      raddr = address_r_in[k*ADDR_W +: ADDR_W];
      rdata_d[k*DATA_W +: DATA_W] = regs_q[raddr];
`ifdef RF_BYPASS_EN
      if (wr_ok && (raddr == address_c_in)) begin
        rdata_d[k*DATA_W +: DATA_W] = data_in;
      end
`endif
      rbusy_d[k] = busy_d[raddr];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
      busy_q  <= '0;
      rdata_q <= '0;
      rbusy_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign reg_r_out  = rdata_q;
  assign busy_r_out = rbusy_q;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_list
      assign rf_list_out[gi*DATA_W +: DATA_W] = regs_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: directed scenarios plus random traffic
// checked against an array-based reference model (honours RF_BYPASS_EN when defined).
module tb_multiport_register_file;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 2**AW;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NR*AW-1:0]     address_r_in;
  logic [NR*DW-1:0]     reg_r_out;
  logic [NR-1:0]        busy_r_out;
  logic [AW-1:0]        address_c_in;
  logic [DW-1:0]        data_in;
  logic                 rf_write_in;
  logic                 issue_in;
  logic [AW-1:0]        address_issue_in;
  logic [DEPTH*DW-1:0]  rf_list_out;

  multiport_register_file #(.DATA_W(DW), .ADDR_W(AW), .NUM_READ(NR)) dut (
    .clk(clk), .reset(reset), .address_r_in(address_r_in), .reg_r_out(reg_r_out),
    .busy_r_out(busy_r_out), .address_c_in(address_c_in), .data_in(data_in),
    .rf_write_in(rf_write_in), .issue_in(issue_in), .address_issue_in(address_issue_in),
    .rf_list_out(rf_list_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR*DW-1:0]    data;
    logic [NR-1:0]       busy;
    logic [DEPTH*DW-1:0] list;
  } exp_t;

  exp_t sb_q[$];
  int total = 0;
  int bad = 0;
  int txn = 0;

  // Reference model state
  logic [DW-1:0] m_regs [DEPTH];
  logic          m_busy [DEPTH];

  task automatic drive(input bit rst, input bit wr, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input bit iss, input logic [AW-1:0] ia,
                       input logic [AW-1:0] r0, input logic [AW-1:0] r1);
    exp_t e;
    logic [AW-1:0] ra [NR];
    @(negedge clk);
    reset = rst; rf_write_in = wr; address_c_in = wa; data_in = wd;
    issue_in = iss; address_issue_in = ia; address_r_in = {r1, r0};
    ra[0] = r0; ra[1] = r1;
    for (int k = 0; k < NR; k++) begin
      e.data[k*DW +: DW] = (ra[k] == 0) ? '0 : m_regs[ra[k]];
`ifdef RF_BYPASS_EN
      if (wr && wa != 0 && ra[k] == wa) e.data[k*DW +: DW] = wd;
`endif
    end
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end
      e.data = '0;
    end else begin
      if (wr && wa != 0) m_regs[wa] = wd;
      if (wr) m_busy[wa] = 1'b0;
      if (iss && ia != 0) m_busy[ia] = 1'b1;
    end
    for (int k = 0; k < NR; k++) e.busy[k] = m_busy[ra[k]];
    for (int i = 0; i < DEPTH; i++) e.list[i*DW +: DW] = m_regs[i];
    @(posedge clk);
    sb_q.push_back(e);
    #1;
    reset = 1'b0; rf_write_in = 1'b0; issue_in = 1'b0;
  endtask

  // Extra constant check on the outputs of the transaction just driven.
  task automatic expect_now(input string name, input bit chk_d, input logic [NR*DW-1:0] d,
                            input logic [NR-1:0] b);
    @(negedge clk);
    if (chk_d) begin
      total++;
      if (reg_r_out !== d) begin
        bad++;
        $display("FAIL %s data got %h want %h", name, reg_r_out, d);
      end
    end
    total++;
    if (busy_r_out !== b) begin
      bad++;
      $display("FAIL %s busy got %b want %b", name, busy_r_out, b);
    end
  endtask

  // Monitor: one expected response per captured transaction
  initial begin
    exp_t e;
    int bad_idx;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        txn++;
        $display("txn %0d: rdata=%h busy=%b", txn, reg_r_out, busy_r_out);
        total++;
        if (reg_r_out !== e.data) begin
          bad++;
          $display("FAIL rdata txn %0d got %h want %h", txn, reg_r_out, e.data);
        end
        total++;
        if (busy_r_out !== e.busy) begin
          bad++;
          $display("FAIL busy txn %0d got %b want %b", txn, busy_r_out, e.busy);
        end
        total++;
        bad_idx = -1;
        for (int i = DEPTH - 1; i >= 0; i--)
          if (rf_list_out[i*DW +: DW] !== e.list[i*DW +: DW]) bad_idx = i;
        if (bad_idx >= 0) begin
          bad++;
          $display("FAIL list txn %0d reg %0d got %h want %h", txn, bad_idx,
                   rf_list_out[bad_idx*DW +: DW], e.list[bad_idx*DW +: DW]);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] bypass_exp;
    reset = 1'b1; rf_write_in = 1'b0; issue_in = 1'b0; address_c_in = '0;
    data_in = '0; address_issue_in = '0; address_r_in = '0;
    for (int i = 0; i < DEPTH; i++) begin m_regs[i] = '0; m_busy[i] = 1'b0; end

    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 1, 9, 32'h1111_1111, 1, 9, 9, 0);
    expect_now("reset_state", 1, '0, 2'b00);

    // Basic write then read of two registers
    drive(0, 1, 10, 32'hffff_ffaa, 0, 0, 0, 0);
    drive(0, 1, 17, 32'hacf2_255b, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 10, 17);
    expect_now("read_r10_r17", 1, {32'hacf2_255b, 32'hffff_ffaa}, 2'b00);

    // Register 0 is hardwired
    drive(0, 1, 0, 32'hcccc_cccc, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    expect_now("r0_zero", 1, '0, 2'b00);
    total++;
    if (rf_list_out[DW-1:0] !== '0) begin
      bad++;
      $display("FAIL r0_list got %h want 0", rf_list_out[DW-1:0]);
    end

    // Issue then complete
    drive(0, 0, 0, 0, 1, 5, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    expect_now("r5_busy", 1, '0, 2'b11);
    drive(0, 1, 5, 32'h1234_5678, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 5, 5);
    expect_now("r5_done", 1, {32'h1234_5678, 32'h1234_5678}, 2'b00);

    // Issue/write collisions
    drive(0, 1, 7, 32'h1, 1, 7, 7, 7);
    expect_now("r7_issue_wins", 0, '0, 2'b11);
    drive(0, 1, 7, 32'h2, 1, 8, 7, 8);
    expect_now("r7_r8_split", 0, '0, 2'b10);
    drive(0, 0, 0, 0, 0, 0, 7, 8);
    expect_now("r7_r8_read", 1, {32'h0, 32'h2}, 2'b10);

    // Same-edge write and read
`ifdef RF_BYPASS_EN
    bypass_exp = 32'hdead_beef;
`else
    bypass_exp = 32'h0;
`endif
    drive(0, 1, 3, 32'hdead_beef, 0, 0, 3, 3);
    expect_now("r3_same_edge", 1, {bypass_exp, bypass_exp}, 2'b00);

    // Reset mid-sequence discards the concurrent write and issue
    drive(0, 1, 1, 32'ha1, 0, 0, 0, 0);
    drive(0, 1, 2, 32'ha2, 0, 0, 0, 0);
    drive(0, 1, 4, 32'ha4, 1, 2, 0, 0);
    drive(1, 1, 4, 32'h55, 1, 6, 2, 4);
    expect_now("reset_out", 1, '0, 2'b00);
    total++;
    if (rf_list_out !== '0) begin
      bad++;
      $display("FAIL reset_list got nonzero want 0");
    end
    drive(0, 1, 9, 32'h99, 1, 11, 2, 4);
    expect_now("after_reset", 1, '0, 2'b00);

    // Random traffic, addresses biased toward a few registers to force collisions
    for (int n = 0; n < 300; n++) begin
      logic [AW-1:0] wa, ia, r0, r1;
      wa = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      ia = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      r0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 5)) : AW'($urandom);
      r1 = ($urandom_range(0, 1) == 1) ? r0 : AW'($urandom_range(0, 5));
      drive(($urandom_range(0, 39) == 0), $urandom_range(0, 1) == 1, wa, $urandom,
            $urandom_range(0, 2) == 0, ia, r0, r1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    for (int w = 0; w < 10 && sb_q.size() > 0; w++) @(negedge clk);
    if (sb_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain left %0d want 0", sb_q.size());
    end
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
